// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: one shared period counter, double-buffered duties, runtime period.
// Define PWM_GEN_CENTER_EN to build the up/down counter and honour the mode input.
module pwm_multi_gen #(
  parameter int CH         = 4,
  parameter int CNT_W      = 15,
  parameter int PERIOD_RST = 25000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CNT_W-1:0]      period,
  input  logic                  mode,
  input  logic [CH*CNT_W-1:0]   duty,
  input  logic                  duty_wr,
  output logic [CH-1:0]         pwm_out,
  output logic                  sync,
  output logic                  upd_pending
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_a_q, period_a_d;
  logic [CNT_W-1:0] p_eff, p_last;
  logic [CNT_W-1:0] duty_a_q [CH];
  logic [CNT_W-1:0] duty_a_d [CH];
  logic [CNT_W-1:0] duty_s_q [CH];
  logic [CNT_W-1:0] duty_s_d [CH];
  logic             pending_q, pending_d;
  logic [CH-1:0]    pwm_q, pwm_d;
  logic             sync_q, sync_d;
  logic             boundary;
  logic             apply;

  // Periods below 2 would leave no room for a wrap, so clamp.
  assign p_eff  = (period_a_q < CNT_W'(2)) ? CNT_W'(2) : period_a_q;
  assign p_last = p_eff - CNT_W'(1);

  // While disabled the active registers track their inputs every cycle.
  assign apply = !en || boundary;

`ifdef PWM_GEN_CENTER_EN
  logic mode_a_q, mode_a_d;
  logic dir_q, dir_d;  // 1 = counting down

  // With P == 2 the down leg is empty, so the top count is also the boundary.
  assign boundary = mode_a_q ? ((cnt_q == CNT_W'(1)) && (dir_q || (p_last == CNT_W'(1))))
                             : (cnt_q >= p_last);
  assign mode_a_d = apply ? mode : mode_a_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    dir_d = dir_q;
    if (!en || boundary) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (mode_a_q) begin
      if (dir_q) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (cnt_q >= p_last) begin
        dir_d = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_a_q <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      mode_a_q <= mode_a_d;
      dir_q    <= dir_d;
    end
  end
`else
  logic mode_unused;
  assign mode_unused = mode;

  assign boundary = (cnt_q >= p_last);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!en || boundary) begin
      cnt_d = '0;
    end
  end
`endif

  assign period_a_d = apply ? period : period_a_q;
  assign sync_d     = en && (cnt_q == '0);

  // A write in the boundary cycle lands in the shadow and keeps pending set.
  always_comb begin
    pending_d = pending_q;
    if (apply) begin
      pending_d = 1'b0;
    end
    if (duty_wr) begin
      pending_d = 1'b1;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    assign duty_s_d[gi] = duty_wr ? duty[gi*CNT_W +: CNT_W] : duty_s_q[gi];
    assign duty_a_d[gi] = (apply && pending_q) ? duty_s_q[gi] : duty_a_q[gi];
    assign pwm_d[gi]    = en && (cnt_q < duty_a_q[gi]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      period_a_q <= CNT_W'(PERIOD_RST);
      pending_q  <= 1'b0;
      pwm_q      <= '0;
      sync_q     <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        duty_a_q[i] <= '0;
        duty_s_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      period_a_q <= period_a_d;
      pending_q  <= pending_d;
      pwm_q      <= pwm_d;
      sync_q     <= sync_d;
      for (int i = 0; i < CH; i++) begin
        duty_a_q[i] <= duty_a_d[i];
        duty_s_q[i] <= duty_s_d[i];
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign sync        = sync_q;
  assign upd_pending = pending_q;

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen: reset, duty buffering, boundary writes, period change, mode.
module tb_pwm_multi_gen;

  localparam int CH    = 4;
  localparam int CNT_W = 15;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [CNT_W-1:0]    period;
  logic                mode;
  logic [CH*CNT_W-1:0] duty;
  logic                duty_wr;
  logic [CH-1:0]       pwm_out;
  logic                sync;
  logic                upd_pending;

  int tests = 0;
  int fails = 0;

  // bit layout per sample: [CH-1:0] pwm, [CH] sync, [CH+1] upd_pending
  logic [CH+1:0] smp_log [64];

  pwm_multi_gen #(.CH(CH), .CNT_W(CNT_W), .PERIOD_RST(25000)) dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .mode(mode),
    .duty(duty), .duty_wr(duty_wr), .pwm_out(pwm_out), .sync(sync),
    .upd_pending(upd_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_duty(input int d3, input int d2, input int d1, input int d0);
    duty = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      smp_log[i] = {upd_pending, sync, pwm_out};
    end
  endtask

  function automatic logic [63:0] col(input int c, input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = smp_log[i][c];
    return v;
  endfunction

  task automatic wait_sync();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!sync && n < 100);
    tests++;
    if (!sync) begin
      fails++;
      $display("FAIL wait_sync: no sync within %0d cycles, required a pulse", n);
    end
  endtask

  task automatic measure_gap(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sync && n < 100);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; period = 15'd10; mode = 1'b0; duty_wr = 1'b0;
    set_duty(0, 0, 0, 0);
    #22;
    tests++;
    if ({pwm_out, sync, upd_pending} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got pwm=%b sync=%b pend=%b, required all 0", pwm_out, sync, upd_pending);
    end
    step();
    rst = 1'b1;
    step();
    $display("[TB] reset released");
  endtask

  task automatic test_basic();
    logic [63:0] v;
    set_duty(12, 10, 3, 0);
    duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
    tests++;
    if (upd_pending !== 1'b1) begin
      fails++; $display("FAIL basic_pend_set: got %b, required 1", upd_pending);
    end
    step();
    tests++;
    if (upd_pending !== 1'b0) begin
      fails++; $display("FAIL basic_pend_applied_disabled: got %b, required 0", upd_pending);
    end
    en = 1'b1;
    capture(20);
    v = col(0, 20); tests++;
    if (v[19:0] !== 20'h00000) begin fails++; $display("FAIL basic_ch0: got %h, required %h", v[19:0], 20'h00000); end
    v = col(1, 20); tests++;
    if (v[19:0] !== 20'h01C07) begin fails++; $display("FAIL basic_ch1: got %h, required %h", v[19:0], 20'h01C07); end
    v = col(2, 20); tests++;
    if (v[19:0] !== 20'hFFFFF) begin fails++; $display("FAIL basic_ch2: got %h, required %h", v[19:0], 20'hFFFFF); end
    v = col(3, 20); tests++;
    if (v[19:0] !== 20'hFFFFF) begin fails++; $display("FAIL basic_ch3: got %h, required %h", v[19:0], 20'hFFFFF); end
    v = col(CH, 20); tests++;
    if (v[19:0] !== 20'h00401) begin fails++; $display("FAIL basic_sync: got %h, required %h", v[19:0], 20'h00401); end
    $display("[TB] basic run: ch1=%h sync=%h", col(1, 20), col(CH, 20));
  endtask

  task automatic test_duty_update();
    logic [63:0] v;
    logic s0, s1;
    wait_sync();
    s0 = pwm_out[1];
    set_duty(12, 10, 7, 0);
    duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
    s1 = pwm_out[1];
    tests++;
    if (upd_pending !== 1'b1) begin fails++; $display("FAIL upd_pend_rise: got %b, required 1", upd_pending); end
    capture(18);
    v = col(1, 18); tests++;
    if ({v[7:0], s1, s0} !== 10'h007) begin
      fails++; $display("FAIL upd_cur_period: got %h, required %h", {v[7:0], s1, s0}, 10'h007);
    end
    tests++;
    if (v[17:8] !== 10'h07F) begin fails++; $display("FAIL upd_next_period: got %h, required %h", v[17:8], 10'h07F); end
    v = col(CH+1, 18); tests++;
    if (v[7:0] !== 8'h7F) begin fails++; $display("FAIL upd_pend_drop: got %h, required %h", v[7:0], 8'h7F); end
    v = col(CH, 18); tests++;
    if (v[17:0] !== 18'h00100) begin fails++; $display("FAIL upd_sync: got %h, required %h", v[17:0], 18'h00100); end
    $display("[TB] duty update 3->7: ch1=%h", col(1, 18));
  endtask

  task automatic test_boundary_write();
    logic [63:0] v;
    wait_sync();
    set_duty(12, 10, 5, 0);
    duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
    repeat (7) step();
    set_duty(12, 10, 2, 0);
    duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
    tests++;
    if (upd_pending !== 1'b1) begin fails++; $display("FAIL bnd_pend_kept: got %b, required 1", upd_pending); end
    capture(20);
    v = col(1, 20); tests++;
    if (v[19:0] !== 20'h00C1F) begin fails++; $display("FAIL bnd_ch1: got %h, required %h", v[19:0], 20'h00C1F); end
    v = col(CH+1, 20); tests++;
    if (v[19:0] !== 20'h001FF) begin fails++; $display("FAIL bnd_pend: got %h, required %h", v[19:0], 20'h001FF); end
    $display("[TB] boundary write: ch1=%h pend=%h", col(1, 20), col(CH+1, 20));
  endtask

  task automatic test_period_change();
    int g;
    wait_sync();
    repeat (4) step();
    period = 15'd20;
    measure_gap(g); tests++;
    if (g !== 6) begin fails++; $display("FAIL per_finish10: got gap %0d, required 6", g); end
    measure_gap(g); tests++;
    if (g !== 20) begin fails++; $display("FAIL per_next20: got gap %0d, required 20", g); end
    period = 15'd1;
    measure_gap(g); tests++;
    if (g !== 20) begin fails++; $display("FAIL per_finish20: got gap %0d, required 20", g); end
    measure_gap(g); tests++;
    if (g !== 2) begin fails++; $display("FAIL per_min2: got gap %0d, required 2", g); end
    measure_gap(g); tests++;
    if (g !== 2) begin fails++; $display("FAIL per_min2_again: got gap %0d, required 2", g); end
    tests++;
    if (pwm_out !== 4'b1110) begin fails++; $display("FAIL per_min2_pwm: got %b, required 1110", pwm_out); end
    $display("[TB] period change checked, last gap %0d", g);
  endtask

`ifdef PWM_GEN_CENTER_EN
  task automatic test_mode();
    int g;
    logic s0;
    logic [63:0] v;
    set_duty(12, 10, 4, 0);
    duty_wr = 1'b1; mode = 1'b1; period = 15'd10;
    step();
    duty_wr = 1'b0;
    measure_gap(g);
    measure_gap(g); tests++;
    if (g !== 18) begin fails++; $display("FAIL center_gap: got %0d, required 18", g); end
    s0 = pwm_out[1];
    capture(17);
    v = col(1, 17); tests++;
    if ({v[16:0], s0} !== 18'h3800F) begin
      fails++; $display("FAIL center_ch1: got %h, required %h", {v[16:0], s0}, 18'h3800F);
    end
    v = col(CH, 17); tests++;
    if (v[16:0] !== 17'h0) begin fails++; $display("FAIL center_sync: got %h, required 0", v[16:0]); end
    mode = 1'b0;
    $display("[TB] center mode: gap %0d", g);
  endtask
`else
  task automatic test_mode();
    int g;
    mode = 1'b1; period = 15'd10;
    measure_gap(g);
    measure_gap(g); tests++;
    if (g !== 10) begin fails++; $display("FAIL mode_ignored_gap: got %0d, required 10", g); end
    measure_gap(g); tests++;
    if (g !== 10) begin fails++; $display("FAIL mode_ignored_gap2: got %0d, required 10", g); end
    mode = 1'b0;
    $display("[TB] mode ignored: gap %0d", g);
  endtask
`endif

  task automatic test_reset_mid();
    logic [63:0] v;
    logic [63:0] any_pwm;
    period = 15'd10; mode = 1'b0;
    set_duty(5, 5, 5, 5);
    duty_wr = 1'b1;
    step();
    duty_wr = 1'b0;
    tests++;
    if (upd_pending !== 1'b1 || pwm_out[3] !== 1'b1) begin
      fails++; $display("FAIL rstmid_pre: got pend=%b ch3=%b, required 1 1", upd_pending, pwm_out[3]);
    end
    #3 rst = 1'b0;
    #1;
    tests++;
    if ({pwm_out, sync, upd_pending} !== 6'b0) begin
      fails++; $display("FAIL rstmid_async: got pwm=%b sync=%b pend=%b, required all 0", pwm_out, sync, upd_pending);
    end
    step();
    rst = 1'b1;
    capture(30);
    v = col(CH, 30); tests++;
    if (v[29:0] !== 30'h1) begin fails++; $display("FAIL rstmid_period: sync got %h, required %h", v[29:0], 30'h1); end
    any_pwm = col(0, 30) | col(1, 30) | col(2, 30) | col(3, 30) | col(CH+1, 30);
    tests++;
    if (any_pwm[29:0] !== 30'h0) begin fails++; $display("FAIL rstmid_duty0: got %h, required 0", any_pwm[29:0]); end
    $display("[TB] mid-period reset: sync=%h", col(CH, 30));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty_update();
    test_boundary_write();
    test_period_change();
    test_mode();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
